reg_file_mp: RTL
================

// Module: reg_file_mp
// PURPOSE
//   Parametrised multi-port register file for the core datapath. N synchronous
//   read ports, one write port with optional write-to-read bypass, optional
//   hardwired-zero R0, and a per-register busy scoreboard for decode-stage
//   hazard checks. Sits between decode (reads, reservations) and writeback.
// PARAMETERS
//   NUM_REGS   8   number of architectural registers (>=2; need not be 2^n)
//   DATA_W     32  register width in bits
//   NUM_RD     2   number of read ports (1..4)
//   ZERO_R0    0   1: R0 reads 0, writes/reservations to R0 ignored
//   BYPASS     1   1: same-cycle write forwarded to a read of the same addr
//   AW (local) $clog2(NUM_REGS) address width
// PORTS
//   clk       in   1            rising-edge clock
//   rst       in   1            synchronous, active-high reset
//   rd_en     in   NUM_RD       per-port read enable
//   rd_addr   in   NUM_RD*AW    packed read addresses, port p at [p*AW +: AW]
//   rd_data   out  NUM_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
//   rd_busy   out  NUM_RD       registered busy bit of the register read on port p
//   wr_en     in   1            writeback enable
//   wr_addr   in   AW           writeback address
//   wr_data   in   DATA_W       writeback data
//   rsv_en    in   1            reserve destination (set busy)
//   rsv_addr  in   AW           register to reserve
//   busy_vec  out  NUM_REGS     current scoreboard, bit i = register i pending
// BEHAVIOUR
//   - Reset (rst=1 at edge): all registers, rd_data, rd_busy, busy_vec -> 0.
//     Writes/reservations presented in the reset cycle are dropped.
//   - Write: at edge with wr_en=1 and wr_addr<NUM_REGS, reg[wr_addr]<=wr_data.
//     Also clears busy[wr_addr].
//   - Read: latency 1. At edge with rd_en[p]=1, rd_data[p]<=value of rd_addr[p]
//     and rd_busy[p]<=busy[rd_addr[p]]. rd_en[p]=0: rd_data[p]/rd_busy[p] hold.
//   - Bypass (BYPASS=1): read and write of same addr in same cycle -> rd_data
//     gets wr_data, rd_busy gets 0 (unless a same-cycle reservation re-sets it).
//     BYPASS=0: rd_data gets the old value, rd_busy the old busy bit.
//   - Reservation: at edge with rsv_en=1 and rsv_addr<NUM_REGS, busy[rsv_addr]<=1.
//   - Set/clear collision (rsv and wr to same addr same cycle): set wins,
//     busy stays 1 (new producer outstanding); data write still happens.
//   - Out of range (addr>=NUM_REGS): writes/reservations ignored; reads
//     return 0 with rd_busy 0.
//   - ZERO_R0=1: reads of R0 return 0, busy 0; writes/reservations to R0 ignored.
//   - Multiple read ports may target same addr; all return identical data.
//   - busy_vec is the registered scoreboard (no bypass); updates visible the
//     cycle after the causing edge.
// STRUCTURE
//   - rf_pkg: localparam RF_MAX_RD=4; function rf_aw(n) returning clog2 with
//     minimum 1; shared by decode and writeback.
//   - Sub-module rf_scoreboard: NUM_REGS busy flops, set/clear ports, set-wins
//     priority, range and R0 masking. Data array and read muxes stay in top.
//   - Read ports built with a generate loop over NUM_RD.
// TESTING
//   1 Reset: write 0xDEADBEEF to R3, assert rst 1 cycle, read R3 -> 0x00000000,
//     busy_vec==0.
//   2 Write/read latency: wr R5=0x12345678; next cycle rd_en[0], addr 5 -> data
//     valid one edge later; rd_en low next cycle -> rd_data holds 0x12345678.
//   3 Bypass: R2=0x11; same cycle wr R2=0x22 and read R2 on both ports ->
//     BYPASS=1 both show 0x22; BYPASS=0 both show 0x11.
//   4 Scoreboard: rsv R4 -> busy_vec[4]=1, read R4 gives rd_busy=1; wr R4 -> 0;
//     rsv and wr R4 same cycle -> busy_vec[4] stays 1, reg value updated.
//   5 ZERO_R0=1: wr R0=0xFFFFFFFF and rsv R0 -> read R0 = 0, busy_vec[0]=0.
//   6 NUM_REGS=6: wr addr 7 = 0xAA -> no register changes; read addr 7 -> 0.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared register-file definitions used by decode, writeback and the register file itself.
// Address width helper plus the range/R0 filter applied to every write and reservation.
package rf_pkg;

  localparam int RF_MAX_RD = 4;

  // $clog2 returns 0 for a 1-entry file, but an address bus still needs one bit.
  function automatic int rf_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic rf_addr_ok(input int addr, input int num_regs, input logic zero_r0);
    return (addr < num_regs) && !(zero_r0 && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bundle for the multi-port register file.
// The master side drives reads, writebacks and reservations. The slave side returns data and busy state.
interface reg_file_mp_if #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 2
);
  import rf_pkg::*;

  localparam int AW = rf_aw(NUM_REGS);

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;
  logic [NUM_REGS-1:0]      busy_vec;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy scoreboard. A reservation sets a bit and a writeback clears it.
// When a set and a clear hit the same register, the set wins because a newer producer is outstanding.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ZERO_R0  = 0,
  parameter int AW       = rf_aw(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                set_ok;
  logic                clr_ok;

  assign set_ok = set_en && rf_addr_ok(int'(set_addr), NUM_REGS, ZERO_R0 != 0);
  assign clr_ok = clr_en && rf_addr_ok(int'(clr_addr), NUM_REGS, ZERO_R0 != 0);

  // The clear is applied first so that a same-address set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_ok) busy_d[clr_addr] = 1'b0;
    if (set_ok) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with a registered read on every port and a single writeback port.
// It supports optional write-to-read bypass, an optional hardwired-zero R0 and a busy scoreboard.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_R0  = 0,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);

  localparam int AW = rf_aw(NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_hit;
  logic                rsv_hit;

  assign wr_hit  = bus.wr_en  && rf_addr_ok(int'(bus.wr_addr),  NUM_REGS, ZERO_R0 != 0);
  assign rsv_hit = bus.rsv_en && rf_addr_ok(int'(bus.rsv_addr), NUM_REGS, ZERO_R0 != 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_R0  (ZERO_R0),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.rsv_en),
    .set_addr (bus.rsv_addr),
    .clr_en   (bus.wr_en),
    .clr_addr (bus.wr_addr),
    .busy     (busy)
  );

  assign bus.busy_vec = busy;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]     addr;
    logic              addr_ok;
    logic              fwd;
    logic [DATA_W-1:0] data_d;
    logic              busy_d;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;

    assign addr    = bus.rd_addr[p*AW +: AW];
    assign addr_ok = rf_addr_ok(int'(addr), NUM_REGS, ZERO_R0 != 0);
    assign fwd     = (BYPASS != 0) && wr_hit && (bus.wr_addr == addr);

    // A forwarded read sees the retiring value. Its busy bit reflects only a same-cycle re-reservation.
    always_comb begin
      data_d = '0;
      busy_d = 1'b0;
      if (addr_ok) begin
        if (fwd) begin
          data_d = bus.wr_data;
          busy_d = rsv_hit && (bus.rsv_addr == addr);
        end else begin
          data_d = regs[addr];
          busy_d = busy[addr];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else if (bus.rd_en[p]) begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end

    assign bus.rd_data[p*DATA_W +: DATA_W] = data_q;
    assign bus.rd_busy[p]                  = busy_q;
  end

endmodule
